// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: mode encoding, control tokens, TERC4 symbols and a popcount helper.
// The TERC4 table is used only when TMDS_TERC4_EN is defined.
package tmds_pkg;

  typedef enum logic [1:0] {
    TMDS_CTRL  = 2'd0,
    TMDS_VIDEO = 2'd1,
    TMDS_DATA  = 2'd2
  } tmds_mode_e;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  // Index 0 is the leftmost entry.
  localparam logic [0:15][9:0] TERC4_TABLE = {
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_TOK_00;
      2'b01:   return CTRL_TOK_01;
      2'b10:   return CTRL_TOK_10;
      default: return CTRL_TOK_11;
    endcase
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Combinational transition-minimising stage: byte in, 9-bit q_m out.
// Bit 8 of q_m flags the XOR chain.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic [7:0] data,
  output logic [8:0] q_m
);

  logic [3:0] n1;
  logic       use_xnor;

  assign n1       = popcount8(data);
  assign use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);

  always_comb begin
    q_m    = '0;
    q_m[0] = data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    q_m[8] = ~use_xnor;
  end

endmodule

// File: rtl/tmds_encoder_pipe.sv
// Multi-channel TMDS encoder with two enabled cycles of latency: q_m register, then DC balance.
// Define TMDS_TERC4_EN to encode data-island symbols with TERC4; otherwise mode 2 sends control tokens.
module tmds_encoder_pipe
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  ce_in,
  input  logic [NUM_CH*2-1:0]   mode_in,
  input  logic [NUM_CH*8-1:0]   data_in,
  input  logic [NUM_CH*2-1:0]   ctrl_in,
  output logic [NUM_CH*10-1:0]  tmds_out
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [8:0]       q_m_comb;
    logic [8:0]       q_m_reg;
    logic [3:0]       n1_reg;
    logic [1:0]       mode_reg;
    logic [1:0]       ctrl_reg;
    logic [9:0]       sym_reg, sym_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] n1_w, n0_w, diff;
    logic             cnt_zero, cnt_pos, cnt_neg;

    tmds_qm_stage u_qm (
      .data (data_in[8*gi +: 8]),
      .q_m  (q_m_comb)
    );

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        q_m_reg  <= '0;
        n1_reg   <= '0;
        mode_reg <= TMDS_CTRL;
        ctrl_reg <= 2'b00;
        sym_reg  <= '0;
        cnt_reg  <= '0;
      end else if (ce_in) begin
        q_m_reg  <= q_m_comb;
        n1_reg   <= popcount8(q_m_comb[7:0]);
        mode_reg <= mode_in[2*gi +: 2];
        ctrl_reg <= ctrl_in[2*gi +: 2];
        sym_reg  <= sym_next;
        cnt_reg  <= cnt_next;
      end
    end

`ifdef TMDS_TERC4_EN
    logic [3:0] nib_reg;
    always_ff @(posedge clk_in) begin
      if (rst_in)     nib_reg <= '0;
      else if (ce_in) nib_reg <= data_in[8*gi +: 4];
    end
`endif

    // Counter math is modular; only the final value has to fit in CNT_W bits.
    assign n1_w     = CNT_W'(n1_reg);
    assign n0_w     = CNT_W'(4'd8 - n1_reg);
    assign diff     = n1_w - n0_w;
    assign cnt_zero = (cnt_reg == '0);
    assign cnt_neg  = cnt_reg[CNT_W-1];
    assign cnt_pos  = !cnt_neg && !cnt_zero;

    always_comb begin
      sym_next = ctrl_token(ctrl_reg);
      cnt_next = '0;
      if (mode_reg == TMDS_VIDEO) begin
        if (cnt_zero || (n1_reg == 4'd4)) begin
          sym_next = {~q_m_reg[8], q_m_reg[8], q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
          cnt_next = q_m_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
        end else if ((cnt_pos && (n1_reg > 4'd4)) || (cnt_neg && (n1_reg < 4'd4))) begin
          sym_next = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
          cnt_next = cnt_reg + (q_m_reg[8] ? CNT_W'(2) : '0) - diff;
        end else begin
          sym_next = {1'b0, q_m_reg[8], q_m_reg[7:0]};
          cnt_next = cnt_reg - (q_m_reg[8] ? '0 : CNT_W'(2)) + diff;
        end
      end
`ifdef TMDS_TERC4_EN
      else if (mode_reg == TMDS_DATA) begin
        sym_next = TERC4_TABLE[nib_reg];
      end
`endif
    end

    assign tmds_out[10*gi +: 10] = sym_reg;
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Directed bench for tmds_encoder_pipe: reset, video/control/data-island symbols, hold, reset mid-stream,
// plus a random video stream scored against an independent reference encoder.
module tb_tmds_encoder_pipe;

  localparam int NS = 300;

`ifdef TMDS_TERC4_EN
  localparam logic [9:0] DI_EXP = 10'b1010011100;
`else
  localparam logic [9:0] DI_EXP = 10'b0010101011;
`endif

  logic        clk = 1'b0;
  logic        rst, ce;
  logic [5:0]  mode, ctrl;
  logic [23:0] data;
  logic [29:0] tout;
  logic signed [4:0] c0;

  int passes = 0;
  int checks = 0;

  logic [29:0] exp_s [NS];
  int          exp_c0 [NS];
  int          mc [3];
  logic [9:0]  s;

  always #5 clk = ~clk;

  tmds_encoder_pipe #(.NUM_CH(3), .CNT_W(5)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .ce_in    (ce),
    .mode_in  (mode),
    .data_in  (data),
    .ctrl_in  (ctrl),
    .tmds_out (tout)
  );

  assign c0 = dut.g_ch[0].cnt_reg;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Reference encoder written straight from the algorithm description.
  function automatic void enc(input logic [7:0] d, inout int c, output logic [9:0] sym);
    logic [8:0] qm;
    int n1d, n1, n0;
    logic xn;
    n1d = $countones(d);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (c == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      c += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      c += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      c += (qm[8] ? 0 : -2) + n1 - n0;
    end
  endfunction

  initial begin
    rst = 1'b1; ce = 1'b1; mode = '0; data = '0; ctrl = '0;
    step(); step();
    chk("rst_out", 32'(tout), 32'h0);
    chk("rst_cnt", int'(c0), 0);

    rst = 1'b0;
    mode = 6'b010101; data = {8'h00, 8'hFF, 8'h00};
    step(); step();
    chk("vid1_out", 32'(tout), 32'({10'h100, 10'h200, 10'h100}));
    chk("vid1_cnt", int'(c0), -8);

    mode = 6'b000000; ctrl = {2'b11, 2'b01, 2'b00};
    step();
    chk("vid2_out", 32'(tout), 32'({10'h3FF, 10'h0FF, 10'h3FF}));
    chk("vid2_cnt", int'(c0), 2);

    mode = {2'b11, 2'b11, 2'b00}; ctrl = {2'b10, 2'b11, 2'b00};
    step();
    chk("ctrl1_out", 32'(tout), 32'({10'h2AB, 10'h0AB, 10'h354}));
    chk("ctrl1_cnt", int'(c0), 0);

    mode = 6'b101010; data = 24'h000000; ctrl = 6'b010101;
    step();
    chk("mode3_out", 32'(tout), 32'({10'h154, 10'h2AB, 10'h354}));

    mode = 6'b010101; data = 24'hFFFFFF;
    step();
    chk("data_isl_out", 32'(tout), 32'({3{DI_EXP}}));
    chk("data_isl_cnt", int'(c0), 0);

    step();
    chk("ff1_out", 32'(tout), 32'({3{10'h200}}));
    chk("ff1_cnt", int'(c0), -8);

    mode = 6'b000000; ctrl = 6'b000000;
    step();
    chk("ff2_out", 32'(tout), 32'({3{10'h0FF}}));
    chk("ff2_cnt", int'(c0), -2);

    // Random video stream; a control symbol is in flight so the counters start at zero.
    mc = '{0, 0, 0};
    mode = 6'b010101;
    for (int i = 0; i < NS; i++) begin
      if (i == 150) begin
        ce = 1'b0;
        for (int h = 0; h < 5; h++) begin
          data = 24'($urandom);
          mode = 6'($urandom);
          ctrl = 6'($urandom);
          step();
          chk("hold_out", 32'(tout), 32'(exp_s[i-2]));
          chk("hold_cnt", int'(c0), exp_c0[i-2]);
        end
        ce = 1'b1;
        mode = 6'b010101;
      end
      data = 24'($urandom);
      for (int k = 0; k < 3; k++) begin
        enc(data[8*k +: 8], mc[k], s);
        exp_s[i][10*k +: 10] = s;
      end
      exp_c0[i] = mc[0];
      step();
      if (i > 0) begin
        chk("stream_out", 32'(tout), 32'(exp_s[i-1]));
        chk("stream_cnt", int'(c0), exp_c0[i-1]);
        chk("stream_bound", 32'(int'(c0) >= -10 && int'(c0) <= 10), 32'h1);
      end
    end
    mode = 6'b000000; ctrl = 6'b000000;
    step();
    chk("stream_last", 32'(tout), 32'(exp_s[NS-1]));

    // Reset mid-stream with ce low: reset must still win and flush the pipeline.
    mode = 6'b010101; data = 24'h000000;
    step(); step();
    chk("pre_rst_out", 32'(tout), 32'({3{10'h100}}));
    chk("pre_rst_cnt", int'(c0), -8);
    rst = 1'b1; ce = 1'b0; data = 24'hA5A5A5;
    step();
    chk("mid_rst_out", 32'(tout), 32'h0);
    chk("mid_rst_cnt", int'(c0), 0);
    rst = 1'b0; ce = 1'b1; data = 24'h000000;
    step();
    chk("post_rst_flush", 32'(tout), 32'({3{10'h354}}));
    step();
    chk("post_rst_out", 32'(tout), 32'({3{10'h100}}));
    chk("post_rst_cnt", int'(c0), -8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
